// File: rtl/mem_issue_queue_pkg.sv
// Shared definitions for the memory issue queue: word/opcode widths, ROB sizing
// and memory opcode encodings (bit 3 set marks a store).
package mem_issue_queue_pkg;
    localparam int WORD_WIDTH        = 32;
    localparam int DATA_WIDTH_MEM_OP = 4;
    localparam int ROB_DEPTH         = 16;
    localparam int ROB_TAG_W         = $clog2(ROB_DEPTH);

    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LOAD_B  = 4'h0;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LOAD_H  = 4'h1;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LOAD_W  = 4'h2;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LOAD_BU = 4'h4;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_LOAD_HU = 4'h5;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SB      = 4'h8;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SH      = 4'h9;
    localparam logic [DATA_WIDTH_MEM_OP-1:0] MEM_OP_SW      = 4'hA;

    function automatic logic is_load(input logic [DATA_WIDTH_MEM_OP-1:0] op);
        return !op[DATA_WIDTH_MEM_OP-1];
    endfunction
endpackage

// File: rtl/mem_iq_entry.sv
// One issue-queue slot: stores a memory op and wakes up its operands from the CDB,
// including a bypass of a broadcast that coincides with the write.
module mem_iq_entry
    import mem_issue_queue_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clear,
    input  logic                         i_write,
    input  logic [DATA_WIDTH_MEM_OP-1:0] i_op,
    input  logic [WORD_WIDTH-1:0]        i_imm,
    input  logic [WORD_WIDTH-1:0]        i_rs1_value,
    input  logic                         i_rs1_ready,
    input  logic [ROB_TAG_W-1:0]         i_rs1_tag,
    input  logic [WORD_WIDTH-1:0]        i_rs2_value,
    input  logic                         i_rs2_ready,
    input  logic [ROB_TAG_W-1:0]         i_rs2_tag,
    input  logic [ROB_TAG_W-1:0]         i_pdst,
    input  logic                         i_cdb_valid,
    input  logic [ROB_TAG_W-1:0]         i_cdb_tag,
    input  logic [WORD_WIDTH-1:0]        i_cdb_value,
    output logic                         o_valid,
    output logic [DATA_WIDTH_MEM_OP-1:0] o_op,
    output logic [WORD_WIDTH-1:0]        o_imm,
    output logic [WORD_WIDTH-1:0]        o_rs1_value,
    output logic                         o_rs1_ready,
    output logic [WORD_WIDTH-1:0]        o_rs2_value,
    output logic                         o_rs2_ready,
    output logic [ROB_TAG_W-1:0]         o_pdst
);
    logic                         r_valid;
    logic [DATA_WIDTH_MEM_OP-1:0] r_op;
    logic [WORD_WIDTH-1:0]        r_imm, r_rs1_value, r_rs2_value;
    logic                         r_rs1_ready, r_rs2_ready;
    logic [ROB_TAG_W-1:0]         r_rs1_tag, r_rs2_tag, r_pdst;

    logic w_in_rs1_hit, w_in_rs2_hit, w_in_rs2_ready;
    logic w_rs1_wake, w_rs2_wake;

    // Incoming-operand match against a broadcast in the same cycle as the write.
    assign w_in_rs1_hit   = i_cdb_valid && !i_rs1_ready && (i_cdb_tag == i_rs1_tag);
    assign w_in_rs2_ready = i_rs2_ready || is_load(i_op);
    assign w_in_rs2_hit   = i_cdb_valid && !w_in_rs2_ready && (i_cdb_tag == i_rs2_tag);

    assign w_rs1_wake = r_valid && !r_rs1_ready && i_cdb_valid && (i_cdb_tag == r_rs1_tag);
    assign w_rs2_wake = r_valid && !r_rs2_ready && i_cdb_valid && (i_cdb_tag == r_rs2_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_op        <= '0;
            r_imm       <= '0;
            r_rs1_value <= '0;
            r_rs2_value <= '0;
            r_rs1_ready <= 1'b0;
            r_rs2_ready <= 1'b0;
            r_rs1_tag   <= '0;
            r_rs2_tag   <= '0;
            r_pdst      <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_write) begin
            r_valid     <= 1'b1;
            r_op        <= i_op;
            r_imm       <= i_imm;
            r_rs1_tag   <= i_rs1_tag;
            r_rs2_tag   <= i_rs2_tag;
            r_pdst      <= i_pdst;
            r_rs1_ready <= i_rs1_ready || w_in_rs1_hit;
            r_rs2_ready <= w_in_rs2_ready || w_in_rs2_hit;
            r_rs1_value <= w_in_rs1_hit ? i_cdb_value : i_rs1_value;
            r_rs2_value <= w_in_rs2_hit ? i_cdb_value : i_rs2_value;
        end else begin
            if (w_rs1_wake) begin
                r_rs1_ready <= 1'b1;
                r_rs1_value <= i_cdb_value;
            end
            if (w_rs2_wake) begin
                r_rs2_ready <= 1'b1;
                r_rs2_value <= i_cdb_value;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_op        = r_op;
    assign o_imm       = r_imm;
    assign o_rs1_value = r_rs1_value;
    assign o_rs1_ready = r_rs1_ready;
    assign o_rs2_value = r_rs2_value;
    assign o_rs2_ready = r_rs2_ready;
    assign o_pdst      = r_pdst;
endmodule

// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: circular FIFO of mem_iq_entry slots, issuing only
// from the head once both operands are ready and the memory side accepts.
module mem_issue_queue
    import mem_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    input  logic [DATA_WIDTH_MEM_OP-1:0] disp_op,
    input  logic [WORD_WIDTH-1:0]        disp_imm,
    input  logic [WORD_WIDTH-1:0]        disp_rs1_value,
    input  logic [WORD_WIDTH-1:0]        disp_rs2_value,
    input  logic                         disp_rs1_ready,
    input  logic                         disp_rs2_ready,
    input  logic [ROB_TAG_W-1:0]         disp_rs1_tag,
    input  logic [ROB_TAG_W-1:0]         disp_rs2_tag,
    input  logic [ROB_TAG_W-1:0]         disp_Pdst,
    output logic                         disp_ready,
    input  logic                         cdb_valid,
    input  logic [ROB_TAG_W-1:0]         cdb_tag,
    input  logic [WORD_WIDTH-1:0]        cdb_value,
    input  logic                         mem_ready,
    output logic                         mem_issue_en,
    output logic [DATA_WIDTH_MEM_OP-1:0] mem_issue_queue_op,
    output logic [WORD_WIDTH-1:0]        mem_issue_queue_imm,
    output logic [WORD_WIDTH-1:0]        mem_issue_queue_rs1_value,
    output logic [WORD_WIDTH-1:0]        mem_issue_queue_rs2_value,
    output logic [ROB_TAG_W-1:0]         mem_issue_queue_Pdst,
    output logic                         queue_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_full, w_enq, w_issue;

    logic                         w_e_valid     [DEPTH];
    logic [DATA_WIDTH_MEM_OP-1:0] w_e_op        [DEPTH];
    logic [WORD_WIDTH-1:0]        w_e_imm       [DEPTH];
    logic [WORD_WIDTH-1:0]        w_e_rs1_value [DEPTH];
    logic                         w_e_rs1_ready [DEPTH];
    logic [WORD_WIDTH-1:0]        w_e_rs2_value [DEPTH];
    logic                         w_e_rs2_ready [DEPTH];
    logic [ROB_TAG_W-1:0]         w_e_pdst      [DEPTH];

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign disp_ready  = !w_full;
    assign queue_empty = (r_count == '0);
    assign w_enq       = disp_valid && disp_ready && !flush;
    assign w_issue     = w_e_valid[r_head] && w_e_rs1_ready[r_head] && w_e_rs2_ready[r_head]
                         && mem_ready && !flush;
    assign mem_issue_en = w_issue;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            mem_iq_entry u_entry (
                .clk         (clk),
                .rst         (rst),
                .i_clear     (flush || (w_issue && (r_head == PTR_W'(gi)))),
                .i_write     (w_enq && (r_tail == PTR_W'(gi))),
                .i_op        (disp_op),
                .i_imm       (disp_imm),
                .i_rs1_value (disp_rs1_value),
                .i_rs1_ready (disp_rs1_ready),
                .i_rs1_tag   (disp_rs1_tag),
                .i_rs2_value (disp_rs2_value),
                .i_rs2_ready (disp_rs2_ready),
                .i_rs2_tag   (disp_rs2_tag),
                .i_pdst      (disp_Pdst),
                .i_cdb_valid (cdb_valid),
                .i_cdb_tag   (cdb_tag),
                .i_cdb_value (cdb_value),
                .o_valid     (w_e_valid[gi]),
                .o_op        (w_e_op[gi]),
                .o_imm       (w_e_imm[gi]),
                .o_rs1_value (w_e_rs1_value[gi]),
                .o_rs1_ready (w_e_rs1_ready[gi]),
                .o_rs2_value (w_e_rs2_value[gi]),
                .o_rs2_ready (w_e_rs2_ready[gi]),
                .o_pdst      (w_e_pdst[gi])
            );
        end
    endgenerate

    // Head fields are shown whenever the head slot holds an op, zero otherwise.
    always_comb begin
        mem_issue_queue_op        = '0;
        mem_issue_queue_imm       = '0;
        mem_issue_queue_rs1_value = '0;
        mem_issue_queue_rs2_value = '0;
        mem_issue_queue_Pdst      = '0;
        if (w_e_valid[r_head]) begin
            mem_issue_queue_op        = w_e_op[r_head];
            mem_issue_queue_imm       = w_e_imm[r_head];
            mem_issue_queue_rs1_value = w_e_rs1_value[r_head];
            mem_issue_queue_rs2_value = w_e_rs2_value[r_head];
            mem_issue_queue_Pdst      = w_e_pdst[r_head];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_issue) begin
                r_head <= r_head + 1'b1;
            end
            if (w_enq && !w_issue) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_issue) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue: hand-computed expectations checked with
// immediate assertions, one line printed per transaction.
module tb_mem_issue_queue;
    import mem_issue_queue_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst, flush;
    logic                         disp_valid;
    logic [DATA_WIDTH_MEM_OP-1:0] disp_op;
    logic [WORD_WIDTH-1:0]        disp_imm, disp_rs1_value, disp_rs2_value;
    logic                         disp_rs1_ready, disp_rs2_ready;
    logic [ROB_TAG_W-1:0]         disp_rs1_tag, disp_rs2_tag, disp_Pdst;
    logic                         disp_ready;
    logic                         cdb_valid;
    logic [ROB_TAG_W-1:0]         cdb_tag;
    logic [WORD_WIDTH-1:0]        cdb_value;
    logic                         mem_ready;
    logic                         mem_issue_en;
    logic [DATA_WIDTH_MEM_OP-1:0] mem_issue_queue_op;
    logic [WORD_WIDTH-1:0]        mem_issue_queue_imm, mem_issue_queue_rs1_value, mem_issue_queue_rs2_value;
    logic [ROB_TAG_W-1:0]         mem_issue_queue_Pdst;
    logic                         queue_empty;

    int checks = 0;
    int failures = 0;

    mem_issue_queue #(.DEPTH(4)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .flush                     (flush),
        .disp_valid                (disp_valid),
        .disp_op                   (disp_op),
        .disp_imm                  (disp_imm),
        .disp_rs1_value            (disp_rs1_value),
        .disp_rs2_value            (disp_rs2_value),
        .disp_rs1_ready            (disp_rs1_ready),
        .disp_rs2_ready            (disp_rs2_ready),
        .disp_rs1_tag              (disp_rs1_tag),
        .disp_rs2_tag              (disp_rs2_tag),
        .disp_Pdst                 (disp_Pdst),
        .disp_ready                (disp_ready),
        .cdb_valid                 (cdb_valid),
        .cdb_tag                   (cdb_tag),
        .cdb_value                 (cdb_value),
        .mem_ready                 (mem_ready),
        .mem_issue_en              (mem_issue_en),
        .mem_issue_queue_op        (mem_issue_queue_op),
        .mem_issue_queue_imm       (mem_issue_queue_imm),
        .mem_issue_queue_rs1_value (mem_issue_queue_rs1_value),
        .mem_issue_queue_rs2_value (mem_issue_queue_rs2_value),
        .mem_issue_queue_Pdst      (mem_issue_queue_Pdst),
        .queue_empty               (queue_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] imm,
                        input logic [31:0] v1, input logic r1, input logic [3:0] t1,
                        input logic [31:0] v2, input logic r2, input logic [3:0] t2,
                        input logic [3:0] pdst);
        disp_valid = 1'b1;     disp_op = op;          disp_imm = imm;
        disp_rs1_value = v1;   disp_rs1_ready = r1;   disp_rs1_tag = t1;
        disp_rs2_value = v2;   disp_rs2_ready = r2;   disp_rs2_tag = t2;
        disp_Pdst = pdst;
        $display("dispatch op=%0h pdst=%0d rs1=%0h/%0b/t%0d rs2=%0h/%0b/t%0d", op, pdst, v1, r1, t1, v2, r2, t2);
    endtask

    task automatic issue_chk(input string tag, input logic [3:0] pdst, input logic [31:0] rs1, input logic [31:0] rs2);
        chk({tag, "_en"},   32'(mem_issue_en), 32'd1);
        chk({tag, "_pdst"}, 32'(mem_issue_queue_Pdst), 32'(pdst));
        chk({tag, "_rs1"},  mem_issue_queue_rs1_value, rs1);
        chk({tag, "_rs2"},  mem_issue_queue_rs2_value, rs2);
        $display("issue pdst=%0d rs1=%0h rs2=%0h", mem_issue_queue_Pdst, mem_issue_queue_rs1_value, mem_issue_queue_rs2_value);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_op = '0; disp_imm = '0;
        disp_rs1_value = '0; disp_rs2_value = '0; disp_rs1_ready = 1'b0; disp_rs2_ready = 1'b0;
        disp_rs1_tag = '0; disp_rs2_tag = '0; disp_Pdst = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; mem_ready = 1'b0;

        // Reset values
        #2;
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_empty", 32'(queue_empty), 32'd1);
        chk("rst_issue_en", 32'(mem_issue_en), 32'd0);
        chk("rst_pdst", 32'(mem_issue_queue_Pdst), 32'd0);
        chk("rst_rs1", mem_issue_queue_rs1_value, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // LW with ready rs1 issues the next cycle
        mem_ready = 1'b1;
        disp(MEM_OP_LOAD_W, 32'd4, 32'h1000, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 4'd3);
        #1;
        chk("lw_pre_issue_en", 32'(mem_issue_en), 32'd0);
        tick();
        disp_valid = 1'b0;
        #1;
        issue_chk("lw", 4'd3, 32'h1000, 32'h0);
        chk("lw_imm", mem_issue_queue_imm, 32'd4);
        chk("lw_op", 32'(mem_issue_queue_op), 32'(MEM_OP_LOAD_W));
        tick();
        chk("lw_empty_after", 32'(queue_empty), 32'd1);
        chk("lw_en_after", 32'(mem_issue_en), 32'd0);

        // SW waiting on rs2 tag 5, woken by CDB two cycles later
        disp(MEM_OP_SW, 32'd8, 32'h2000, 1'b1, 4'd0, 32'h0, 1'b0, 4'd5, 4'd4);
        tick();
        disp_valid = 1'b0;
        #1;
        chk("sw_wait1", 32'(mem_issue_en), 32'd0);
        chk("sw_head_pdst", 32'(mem_issue_queue_Pdst), 32'd4);
        tick();
        chk("sw_wait2", 32'(mem_issue_en), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_value = 32'hDEADBEEF;
        #1;
        chk("sw_no_bypass", 32'(mem_issue_en), 32'd0);
        tick();
        cdb_valid = 1'b0;
        #1;
        issue_chk("sw", 4'd4, 32'h2000, 32'hDEADBEEF);
        tick();
        chk("sw_empty_after", 32'(queue_empty), 32'd1);

        // Fill to full, then drain in order; full blocks dispatch even while issuing
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(MEM_OP_LOAD_W, 32'd0, 32'h100 * i, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 4'(i));
            #1;
            chk("fill_disp_ready", 32'(disp_ready), 32'd1);
            tick();
        end
        disp(MEM_OP_LOAD_W, 32'd0, 32'hBAD, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 4'd9);
        #1;
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        chk("full_no_issue", 32'(mem_issue_en), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("full_issue_disp_ready", 32'(disp_ready), 32'd0);
        issue_chk("drain0", 4'd0, 32'h0, 32'h0);
        tick();
        disp_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            issue_chk("drain", 4'(i), 32'h100 * i, 32'h0);
            tick();
        end
        chk("drain_empty", 32'(queue_empty), 32'd1);
        chk("drain_no_extra", 32'(mem_issue_en), 32'd0);

        // Not-ready head blocks a ready younger entry
        disp(MEM_OP_LOAD_W, 32'd0, 32'h0, 1'b0, 4'd7, 32'h0, 1'b0, 4'd0, 4'd5);
        tick();
        disp(MEM_OP_LOAD_W, 32'd0, 32'h300, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 4'd6);
        #1;
        chk("block_en0", 32'(mem_issue_en), 32'd0);
        tick();
        disp_valid = 1'b0;
        #1;
        chk("block_en1", 32'(mem_issue_en), 32'd0);
        chk("block_head", 32'(mem_issue_queue_Pdst), 32'd5);
        tick();
        chk("block_en2", 32'(mem_issue_en), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_value = 32'h77;
        #1;
        chk("block_en3", 32'(mem_issue_en), 32'd0);
        tick();
        cdb_valid = 1'b0;
        #1;
        issue_chk("unblock_old", 4'd5, 32'h77, 32'h0);
        tick();
        issue_chk("unblock_young", 4'd6, 32'h300, 32'h0);
        tick();
        chk("unblock_empty", 32'(queue_empty), 32'd1);

        // Flush with three entries; dispatch and issue suppressed in the flush cycle
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(MEM_OP_SB, 32'd0, 32'h10, 1'b1, 4'd0, 32'h20, 1'b1, 4'd0, 4'(8 + i));
            tick();
        end
        disp_valid = 1'b0;
        #1;
        chk("pre_flush_empty", 32'(queue_empty), 32'd0);
        flush = 1'b1; mem_ready = 1'b1;
        disp(MEM_OP_LOAD_W, 32'd0, 32'h1, 1'b1, 4'd0, 32'h0, 1'b0, 4'd0, 4'd12);
        #1;
        chk("flush_no_issue", 32'(mem_issue_en), 32'd0);
        $display("flush");
        tick();
        flush = 1'b0; disp_valid = 1'b0;
        #1;
        chk("post_flush_empty", 32'(queue_empty), 32'd1);
        chk("post_flush_disp_ready", 32'(disp_ready), 32'd1);
        chk("post_flush_no_issue", 32'(mem_issue_en), 32'd0);
        tick();
        chk("post_flush_no_issue2", 32'(mem_issue_en), 32'd0);

        // Same-cycle CDB bypass into the entry being enqueued
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_value = 32'h20;
        disp(MEM_OP_LOAD_W, 32'd0, 32'h0, 1'b0, 4'd2, 32'h0, 1'b0, 4'd0, 4'd7);
        tick();
        cdb_valid = 1'b0; disp_valid = 1'b0;
        #1;
        issue_chk("enq_bypass", 4'd7, 32'h20, 32'h0);
        tick();
        chk("enq_bypass_empty", 32'(queue_empty), 32'd1);

        // Asynchronous reset between clock edges discards entries immediately
        mem_ready = 1'b0;
        disp(MEM_OP_SW, 32'd0, 32'h5, 1'b1, 4'd0, 32'h6, 1'b1, 4'd0, 4'd1);
        tick();
        disp_valid = 1'b0;
        #1;
        chk("pre_arst_empty", 32'(queue_empty), 32'd0);
        rst = 1'b1;
        #1;
        $display("async reset");
        chk("arst_empty", 32'(queue_empty), 32'd1);
        chk("arst_disp_ready", 32'(disp_ready), 32'd1);
        chk("arst_pdst", 32'(mem_issue_queue_Pdst), 32'd0);
        chk("arst_rs2", mem_issue_queue_rs2_value, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
